// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle radix-2 restoring divider.
// Optional feature macro: DIV_ZERO_FAST_EN (consumed in div_unit.sv).
package div_pkg;

  // Default operand width; the divider performs one iteration per bit.
  localparam int unsigned DIV_WIDTH = 32;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // Iteration counter width for a given operand width (never below 1 bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor and keeps the difference when it does not go negative.
// Optional feature macro: none (see div_unit.sv for DIV_ZERO_FAST_EN).
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shift_rem;
  logic [WIDTH:0] trial;
  logic           take;

  // Shift, trial subtract and restore-or-keep decision.
  always_comb begin
    shift_rem = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
    trial     = shift_rem - {1'b0, divisor_i};
    // A set top bit on the incoming remainder means the shifted value
    // already exceeds any divisor, so the subtraction must be kept.
    take      = rem_i[WIDTH] | ~trial[WIDTH];
    rem_o     = take ? trial : shift_rem;
    quo_o     = {quo_i[WIDTH-2:0], take};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Holds the pipeline through stall_divE while iterating, then presents
// {hi=remainder, lo=quotient} for one cycle qualified by div_readyE.
// Optional feature macro: DIV_ZERO_FAST_EN (single-cycle divide-by-zero).
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startE,
  input  logic               signedE,
  input  logic [WIDTH-1:0]   srcaE,
  input  logic [WIDTH-1:0]   srcbE,
  input  logic               annulE,
  output logic               stall_divE,
  output logic               div_readyE,
  output logic [2*WIDTH-1:0] div_resultE
);

  localparam int unsigned CW = cnt_width(WIDTH);

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] fixed_res;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  // Operand magnitudes and signed fixup of the finished unsigned result.
  always_comb begin
    a_abs     = (signedE & srcaE[WIDTH-1]) ? -srcaE : srcaE;
    b_abs     = (signedE & srcbE[WIDTH-1]) ? -srcbE : srcbE;
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    fixed_res = {rem_fix, quo_fix};
  end

  // Next-state, datapath loads and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    stall_divE = 1'b0;
    div_readyE = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (startE) begin
          stall_divE = 1'b1;
          cnt_d      = '0;
          rem_d      = '0;
          quo_d      = a_abs;
          dvs_d      = b_abs;
          neg_quo_d  = signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
          neg_rem_d  = signedE & srcaE[WIDTH-1];
          state_d    = ST_BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (srcbE == '0) begin
            // Preload the final registers so DONE emits {srcaE, all-ones}
            // through the normal output path with fixup disabled.
            rem_d     = {1'b0, srcaE};
            quo_d     = '1;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = ST_DONE;
          end
`endif
        end
      end
      ST_BUSY: begin
        stall_divE = 1'b1;
        rem_d      = step_rem;
        quo_d      = step_quo;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        div_readyE = 1'b1;
        result_d   = fixed_res;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (annulE) begin
      state_d    = ST_IDLE;
      stall_divE = 1'b0;
      div_readyE = 1'b0;
      result_d   = result_q;
    end
  end

  // The fresh result is forwarded during DONE and retained afterwards.
  assign div_resultE = div_readyE ? fixed_res : result_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// operands compared against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        startE;
  logic        signedE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        annulE;
  logic        stall_divE;
  logic        div_readyE;
  logic [63:0] div_resultE;

  int total;
  int bad;
  logic [63:0] exp_last;

  div_unit #(
    .WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .startE     (startE),
    .signedE    (signedE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .annulE     (annulE),
    .stall_divE (stall_divE),
    .div_readyE (div_readyE),
    .div_resultE(div_resultE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {hi=remainder, lo=quotient}, truncating division.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint q;
    longint r;
    if (sgn) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'(a) / longint'(b);
      r = longint'(a) % longint'(b);
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Runs one operation with startE held until the ready cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output int stalls, output int ready_cycle,
                       output logic [63:0] res, output logic stall_at_done);
    @(posedge clk); #1;
    startE  = 1'b1;
    signedE = sgn;
    srcaE   = a;
    srcbE   = b;
    stalls        = 0;
    ready_cycle   = -1;
    res           = 'x;
    stall_at_done = 1'bx;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (stall_divE) stalls++;
      if (div_readyE) begin
        ready_cycle   = c;
        res           = div_resultE;
        stall_at_done = stall_divE;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    startE = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (stall_divE !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_divE); end
    total++;
    if (div_readyE !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", div_readyE); end
    total++;
    if (div_resultE !== 64'd0) begin bad++; $display("FAIL reset_result got=%h want=0", div_resultE); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_last = '0;
  endtask

  task automatic test_basic();
    int st, rc, stray;
    logic [63:0] r;
    logic sd;
    do_op(32'd7, 32'd2, 1'b0, st, rc, r, sd);
    total++;
    if (rc !== 33) begin bad++; $display("FAIL basic_latency got=%0d want=33", rc); end
    total++;
    if (st !== 33) begin bad++; $display("FAIL basic_stalls got=%0d want=33", st); end
    total++;
    if (sd !== 1'b0) begin bad++; $display("FAIL basic_stall_in_done got=%b want=0", sd); end
    total++;
    if (r !== {32'd1, 32'd3}) begin bad++; $display("FAIL basic_result got=%h want=%h", r, {32'd1, 32'd3}); end
    exp_last = {32'd1, 32'd3};
    // With startE low nothing further may happen, and the result must persist.
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (stall_divE || div_readyE) stray++;
    end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL basic_no_retrigger got=%0d want=0", stray); end
    total++;
    if (div_resultE !== exp_last) begin bad++; $display("FAIL basic_hold got=%h want=%h", div_resultE, exp_last); end
  endtask

  task automatic test_signed();
    int st, rc;
    logic [63:0] r;
    logic sd;
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, st, rc, r, sd);
    total++;
    if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      bad++; $display("FAIL signed_neg_a got=%h want=%h", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, st, rc, r, sd);
    total++;
    if (r !== {32'd1, 32'hFFFF_FFFD}) begin
      bad++; $display("FAIL signed_neg_b got=%h want=%h", r, {32'd1, 32'hFFFF_FFFD});
    end
    do_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, st, rc, r, sd);
    total++;
    if (r !== ref_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1)) begin
      bad++; $display("FAIL signed_both_neg got=%h want=%h", r, ref_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1));
    end
    exp_last = ref_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
  endtask

  task automatic test_overflow();
    int st, rc;
    logic [63:0] r;
    logic sd;
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, st, rc, r, sd);
    total++;
    if (r !== {32'd0, 32'h8000_0000}) begin
      bad++; $display("FAIL ovf_signed got=%h want=%h", r, {32'd0, 32'h8000_0000});
    end
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, st, rc, r, sd);
    total++;
    if (r !== {32'h8000_0000, 32'd0}) begin
      bad++; $display("FAIL ovf_unsigned got=%h want=%h", r, {32'h8000_0000, 32'd0});
    end
    exp_last = {32'h8000_0000, 32'd0};
  endtask

  task automatic test_random();
    int st, rc;
    logic [63:0] r, e;
    logic [31:0] a, b;
    logic sgn;
    for (int i = 0; i < 30; i++) begin
      a   = $urandom();
      b   = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom();
      if (i % 5 == 1) b = -b;
      if (b == 32'd0) b = 32'd3;
      sgn = 1'($urandom_range(0, 1));
      e   = ref_div(a, b, sgn);
      do_op(a, b, sgn, st, rc, r, sd_dummy);
      total++;
      if (r !== e) begin
        bad++; $display("FAIL rand_result a=%h b=%h s=%b got=%h want=%h", a, b, sgn, r, e);
      end
      total++;
      if (rc !== 33) begin bad++; $display("FAIL rand_latency got=%0d want=33", rc); end
      exp_last = e;
    end
  endtask
  logic sd_dummy;

  task automatic test_annul();
    int seen, st, rc;
    logic [63:0] r;
    logic sd;
    @(posedge clk); #1;
    startE = 1'b1; signedE = 1'b0; srcaE = 32'd1000; srcbE = 32'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    annulE = 1'b1;
    startE = 1'b0;
    @(negedge clk);
    total++;
    if (stall_divE !== 1'b0) begin bad++; $display("FAIL annul_stall got=%b want=0", stall_divE); end
    total++;
    if (div_readyE !== 1'b0) begin bad++; $display("FAIL annul_ready got=%b want=0", div_readyE); end
    total++;
    if (div_resultE !== exp_last) begin bad++; $display("FAIL annul_result got=%h want=%h", div_resultE, exp_last); end
    @(posedge clk); #1;
    annulE = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall_divE || div_readyE) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL annul_abandoned got=%0d want=0", seen); end
    do_op(32'd1000, 32'd7, 1'b0, st, rc, r, sd);
    total++;
    if (r !== {32'd6, 32'd142}) begin bad++; $display("FAIL annul_restart got=%h want=%h", r, {32'd6, 32'd142}); end
    exp_last = {32'd6, 32'd142};
  endtask

  task automatic test_rst_mid();
    int st, rc;
    logic [63:0] r;
    logic sd;
    @(posedge clk); #1;
    startE = 1'b1; signedE = 1'b1; srcaE = 32'd12345; srcbE = 32'd11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    startE = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (stall_divE !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b want=0", stall_divE); end
    total++;
    if (div_readyE !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b want=0", div_readyE); end
    total++;
    if (div_resultE !== 64'd0) begin bad++; $display("FAIL rstmid_result got=%h want=0", div_resultE); end
    for (int k = 0; k < 2; k++) begin
      do_op(32'd100 + 32'(k), 32'd9, 1'b1, st, rc, r, sd);
      total++;
      if (st !== 33) begin bad++; $display("FAIL b2b_stalls k=%0d got=%0d want=33", k, st); end
      total++;
      if (r !== ref_div(32'd100 + 32'(k), 32'd9, 1'b1)) begin
        bad++; $display("FAIL b2b_result k=%0d got=%h want=%h", k, r, ref_div(32'd100 + 32'(k), 32'd9, 1'b1));
      end
    end
  endtask

  task automatic test_div_zero();
    int st, rc;
    logic [63:0] r;
    logic sd;
    do_op(32'd5, 32'd0, 1'b0, st, rc, r, sd);
`ifdef DIV_ZERO_FAST_EN
    total++;
    if (st !== 1) begin bad++; $display("FAIL divzero_stalls got=%0d want=1", st); end
    total++;
    if (rc !== 1) begin bad++; $display("FAIL divzero_latency got=%0d want=1", rc); end
    total++;
    if (r !== {32'd5, 32'hFFFF_FFFF}) begin bad++; $display("FAIL divzero_result got=%h want=%h", r, {32'd5, 32'hFFFF_FFFF}); end
    do_op(32'hFFFF_FFFB, 32'd0, 1'b1, st, rc, r, sd);
    total++;
    if (r !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL divzero_signed got=%h want=%h", r, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    end
`else
    total++;
    if (st !== 33) begin bad++; $display("FAIL divzero_stalls got=%0d want=33", st); end
    total++;
    if (rc !== 33) begin bad++; $display("FAIL divzero_latency got=%0d want=33", rc); end
`endif
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; startE = 1'b0; signedE = 1'b0; annulE = 1'b0;
    srcaE = '0; srcbE = '0; exp_last = '0;
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_random();
    test_annul();
    test_rst_mid();
    test_div_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
